// File: rtl/tx_interp_fir.sv
// -----------------------------------------------------------------------------
// tx_interp_fir
//
// Interpolate-by-2 transmit FIR. Each accepted baseband sample produces two
// output samples, one per polyphase branch of a 26-tap Q15 prototype. Both
// branches share a single multiplier and a single accumulator: phase 0 runs
// 13 MACs, waits for an output-rate tick, then phase 1 runs 13 MACs and waits
// for the next tick.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   baseband sample offered
//   in_ready   block can accept a sample (high only while idle)
//   in_data    signed 10-bit input sample
//   out_tick   one-cycle output-rate strobe (nominally 2x input rate)
//   out_data   signed 10-bit interpolated sample, held between pulses
//   out_valid  one-cycle pulse, out_data updated this cycle
//   underrun   sticky: a tick arrived while no result was pending
// -----------------------------------------------------------------------------
module tx_interp_fir (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [9:0] in_data,
    input  logic              out_tick,
    output logic signed [9:0] out_data,
    output logic              out_valid,
    output logic              underrun
);

    // Even and odd taps of the prototype filter (Q15, signed 17-bit).
    localparam logic signed [16:0] P0 [13] = '{
        17'sd530,   -17'sd210,  17'sd1386,  17'sd427,   -17'sd3849,
        -17'sd2339, 17'sd38766, -17'sd5937, 17'sd4683,  17'sd1617,
        -17'sd1453, -17'sd677,  17'sd1418
    };
    localparam logic signed [16:0] P1 [13] = '{
        17'sd1418,  -17'sd677,  -17'sd1453, 17'sd1617,  17'sd4683,
        -17'sd5937, 17'sd38766, -17'sd2339, -17'sd3849, 17'sd427,
        17'sd1386,  -17'sd210,  17'sd530
    };

    localparam logic [3:0] LAST_TAP = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        WAIT0,
        MAC1,
        WAIT1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [9:0]  hist [0:12];
    logic        [3:0]  k;
    logic signed [31:0] acc;
    logic signed [31:0] res;

    logic signed [16:0] coef;
    logic signed [26:0] prod;
    logic signed [31:0] acc_next;
    logic signed [31:0] res_shr;
    logic signed [9:0]  res_fmt;

    // ------------------------------------------------------------------
    // Shared MAC datapath
    // ------------------------------------------------------------------
    assign coef     = (state == MAC1) ? P1[k] : P0[k];
    assign prod     = hist[k] * coef;
    assign acc_next = acc + {{5{prod[26]}}, prod};

    // Floor (arithmetic shift) back to sample scale, then clamp to 10 bits.
    assign res_shr = res >>> 15;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        res_fmt = res_shr[9:0];
        if (res_shr > 32'sd511) begin
            res_fmt = 10'sd511;
        end else if (res_shr < -32'sd512) begin
            res_fmt = -10'sd512;
        end
    end

    assign in_ready = (state == IDLE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)       state_next = MAC0;
            MAC0:    if (k == LAST_TAP)  state_next = WAIT0;
            WAIT0:   if (out_tick)       state_next = MAC1;
            MAC1:    if (k == LAST_TAP)  state_next = WAIT1;
            WAIT1:   if (out_tick)       state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the history line is reset explicitly so the first sample
            // after reset always convolves against zeros; it is only 13 words.
            for (int i = 0; i < 13; i++) begin
                hist[i] <= '0;
            end
            k         <= '0;
            acc       <= '0;
            res       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            // A tick outside the wait states means the consumer outran us.
            if (out_tick && (state == IDLE || state == MAC0 || state == MAC1)) begin
                underrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 12; i > 0; i--) begin
                            hist[i] <= hist[i-1];
                        end
                        hist[0] <= in_data;
                        acc     <= '0;
                        k       <= '0;
                    end
                end

                MAC0, MAC1: begin
                    acc <= acc_next;
                    if (k == LAST_TAP) begin
                        res <= acc_next;
                        k   <= '0;
                    end else begin
                        k <= k + 4'd1;
                    end
                end

                WAIT0: begin
                    if (out_tick) begin
                        out_data  <= res_fmt;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        k         <= '0;
                    end
                end

                WAIT1: begin
                    if (out_tick) begin
                        out_data  <= res_fmt;
                        out_valid <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_interp_fir.sv
// -----------------------------------------------------------------------------
// tb_tx_interp_fir
//
// Directed bench for tx_interp_fir: reset state, impulse response, DC gain,
// saturation, underrun, reset mid-operation and flow control. Expected values
// are hand-computed floor((x * coef) / 32768) with saturation to 10 bits.
// -----------------------------------------------------------------------------
module tb_tx_interp_fir;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [9:0] in_data;
    logic              out_tick;
    logic signed [9:0] out_data;
    logic              out_valid;
    logic              underrun;

    int n_tests;
    int n_fail;

    // Impulse of 100 through each phase: floor(100 * Pn[k] / 32768).
    int imp_p0 [13] = '{1, -1, 4, 1, -12, -8, 118, -19, 14, 4, -5, -3, 4};
    int imp_p1 [13] = '{4, -3, -5, 4, 14, -19, 118, -8, -12, 1, 4, -1, 1};

    tx_interp_fir dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_tick  (out_tick),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = '0;
        out_tick = 1'b0;
        reset    = 1'b1;
        step(2);
        reset    = 1'b0;
        step(1);
    endtask

    // Offer one sample; returns one step after the accepting edge.
    task automatic send(input logic signed [9:0] din);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step(1);
            guard++;
        end
        if (!in_ready) check("ready_timeout", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = din;
        step(1);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_tick(output logic v, output logic signed [9:0] d);
        out_tick = 1'b1;
        step(1);
        out_tick = 1'b0;
        v = out_valid;
        d = out_data;
    endtask

    // One full sample: accept, tick in WAIT0, tick in WAIT1.
    task automatic sample_pair(input  logic signed [9:0] din,
                               output logic v0, output logic signed [9:0] d0,
                               output logic v1, output logic signed [9:0] d1);
        send(din);
        step(15);
        do_tick(v0, d0);
        step(15);
        do_tick(v1, d1);
    endtask

    task automatic dc_run(input logic signed [9:0] din, input int expected, input string tag);
        logic v0, v1;
        logic signed [9:0] d0, d1;
        for (int i = 0; i < 13; i++) begin
            sample_pair(din, v0, d0, v1, d1);
        end
        check({tag, "_p0"}, int'(d0), expected);
        check({tag, "_p1"}, int'(d1), expected);
        check({tag, "_valid"}, int'(v0 & v1), 1);
    endtask

    initial begin
        logic v0, v1, v;
        logic signed [9:0] d0, d1, d;
        int accepts, pulses, bad, last;

        n_tests  = 0;
        n_fail   = 0;
        in_valid = 1'b0;
        in_data  = '0;
        out_tick = 1'b0;
        reset    = 1'b0;

        // ---------------- Reset state ----------------
        do_reset();
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_underrun",  int'(underrun),  0);

        // ---------------- Impulse response ----------------
        for (int i = 0; i < 13; i++) begin
            sample_pair((i == 0) ? 10'sd100 : 10'sd0, v0, d0, v1, d1);
            check($sformatf("imp%0d_p0", i), int'(d0), imp_p0[i]);
            check($sformatf("imp%0d_p1", i), int'(d1), imp_p1[i]);
            check($sformatf("imp%0d_v", i),  int'(v0 & v1), 1);
            if (i == 0) begin
                step(5);
                check("hold_data",  int'(out_data),  imp_p1[0]);
                check("hold_valid", int'(out_valid), 0);
            end
        end
        sample_pair(10'sd0, v0, d0, v1, d1);
        check("imp_tail_p0", int'(d0), 0);
        check("imp_tail_p1", int'(d1), 0);
        check("imp_no_underrun", int'(underrun), 0);

        // ---------------- Underrun ----------------
        do_reset();
        send(10'sd100);
        step(1);
        do_tick(v, d);                 // third edge after accept: still in MAC0
        check("ur_no_pulse", int'(v), 0);
        check("ur_data_kept", int'(d), 0);
        check("ur_flag", int'(underrun), 1);
        step(12);
        do_tick(v0, d0);
        check("ur_wait0_valid", int'(v0), 1);
        check("ur_wait0_data", int'(d0), 1);
        step(15);
        do_tick(v1, d1);
        check("ur_wait1_data", int'(d1), 4);
        check("ur_sticky", int'(underrun), 1);
        step(20);
        check("ur_sticky_late", int'(underrun), 1);

        // ---------------- DC gain and saturation ----------------
        do_reset();
        dc_run(10'sd256, 268, "dc256");
        do_reset();
        dc_run(10'sd511, 511, "sat_pos");
        dc_run(-10'sd512, -512, "sat_neg");
        check("sat_no_underrun", int'(underrun), 0);

        // ---------------- Reset during MAC1 ----------------
        send(10'sd256);
        step(15);
        do_tick(v0, d0);               // enters MAC1
        step(4);
        reset = 1'b1;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_ready", int'(in_ready), 1);
        step(2);
        reset = 1'b0;
        step(1);
        check("abort_data", int'(out_data), 0);
        check("abort_valid_after", int'(out_valid), 0);
        sample_pair(10'sd100, v0, d0, v1, d1);
        check("abort_imp_p0", int'(d0), 1);
        check("abort_imp_p1", int'(d1), 4);
        sample_pair(10'sd0, v0, d0, v1, d1);
        check("abort_imp1_p0", int'(d0), -1);
        check("abort_imp1_p1", int'(d1), -3);

        // ---------------- Flow control ----------------
        do_reset();
        accepts  = 0;
        pulses   = 0;
        bad      = 0;
        last     = 0;
        in_valid = 1'b1;
        for (int c = 0; c <= 512; c++) begin
            in_data  = in_ready ? 10'sd256 : 10'($urandom_range(0, 1023));
            out_tick = (c > 0) && (c % 16 == 0);
            if (in_valid && in_ready) accepts++;
            step(1);
            if (out_valid) begin
                pulses++;
                last = int'(out_data);
                if (pulses > 26 && out_data != 10'sd268) bad++;
            end
        end
        in_valid = 1'b0;
        out_tick = 1'b0;
        check("flow_accepts", accepts, 16);
        check("flow_pulses", pulses, 32);
        check("flow_bad_outputs", bad, 0);
        check("flow_last", last, 268);
        check("flow_no_underrun", int'(underrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_interp_fir.md
TX_INTERP_FIR -- requirements
Module: tx_interp_fir

Interface
REQ-001 SHALL have no parameters; the coefficient table is fixed (REQ-012).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  baseband sample offered.
REQ-005 in_ready  output  1  block can accept a sample.
REQ-006 in_data  input  10  signed two's-complement input sample.
REQ-007 out_tick  input  1  one-cycle output-rate strobe, nominally 2x the input rate.
REQ-008 out_data  output  10  signed interpolated sample.
REQ-009 out_valid  output  1  one-cycle pulse, out_data updated this cycle.
REQ-010 underrun  output  1  sticky: an out_tick arrived while no result was pending.

Function
REQ-011 SHALL implement interpolate-by-2 as a two-phase polyphase FIR, time-multiplexed over one multiplier and one accumulator.
REQ-012 Prototype C[0..25], signed 17-bit, Q15: 530, 1418, -210, -677, 1386, -1453, 427, 1617, -3849, 4683, -2339, -5937, 38766, 38766, -5937, -2339, 4683, -3849, 1617, 427, -1453, 1386, -677, -210, 1418, 530.
REQ-013 Phase tables: P0[k]=C[2k], P1[k]=C[2k+1], k=0..12.
REQ-014 History h[0..12], signed 10-bit; h[0] is the newest sample.
REQ-015 States: IDLE, MAC0, WAIT0, MAC1, WAIT1.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, in_valid=1 -> shift (h[k]<=h[k-1], h[0]<=in_data), clear acc, k<=0, go MAC0.
REQ-018 MAC0: one product per cycle, acc += h[k]*P0[k].
REQ-019 MAC0 lasts exactly 13 cycles (k=0..12); latch phase result into res, then go WAIT0.
REQ-020 WAIT0, out_tick=1 -> on that edge load out_data<=fmt(res), pulse out_valid, clear acc, k<=0, go MAC1.
REQ-021 MAC1: identical to MAC0 using P1, 13 cycles, then latch res and go WAIT1.
REQ-022 WAIT1, out_tick=1 -> load out_data, pulse out_valid, go IDLE.
REQ-023 Minimum latency from accept edge to res valid SHALL be 14 cycles.
REQ-024 Arithmetic: product 27-bit signed; acc 32-bit signed; overflow impossible for 10-bit inputs.
REQ-025 fmt(x): arithmetic shift right by 15 (floor, no rounding), then saturate to [-512, 511].
REQ-026 out_tick in IDLE, MAC0 or MAC1 SHALL set underrun=1 and leave out_data and out_valid unchanged.
REQ-027 underrun SHALL be cleared only by reset.
REQ-028 out_tick in WAIT0/WAIT1 SHALL never set underrun.
REQ-029 in_valid/in_data outside IDLE SHALL be ignored, with no history change.
REQ-030 Back-to-back input: in_valid high on the IDLE entry cycle SHALL be accepted that cycle, with no bubble.
REQ-031 out_valid SHALL be high for exactly one cycle per accepted out_tick: two pulses per input sample.
REQ-032 out_data SHALL hold its value between out_valid pulses.

Reset
REQ-033 Reset state: IDLE, in_ready=1.
REQ-034 Reset values: out_data=0, out_valid=0, underrun=0, h[*]=0, acc=0, res=0, k=0.
REQ-035 Reset asserted mid-MAC or mid-WAIT SHALL abort immediately to the reset state with no out_valid pulse; the pending result is discarded.
REQ-036 After reset deasserts, the first accepted sample SHALL see zero history.

Verification
REQ-037 Impulse: from reset, in_data=100 once, out_tick every 20 cycles -> out_data 1, then 4 (100*530>>15, 100*1418>>15); next zero inputs follow P0/P1 x100 with floor.
REQ-038 DC: constant in_data=256 for 13+ samples -> every output is 268.
REQ-039 Saturation: constant 511 -> 511; constant -512 -> -512 (unsaturated values 535 and -537).
REQ-040 Underrun: out_tick asserted 3 cycles after accept (during MAC0) -> underrun=1, no out_valid pulse; a later tick in WAIT0 still emits; underrun stays 1 until reset.
REQ-041 Reset mid-operation: reset in MAC1 cycle 5 -> out_valid=0, in_ready=1 and h=0 after release; next impulse of 100 reproduces the 1, 4 sequence.
REQ-042 Flow control: in_valid held high with out_tick every 16 cycles -> exactly one accept per two out_valid pulses; in_data changes while in_ready=0 are not captured.
